// File: rtl/ro_frame_packer.sv
// ro_frame_packer: captures one readout-bus word per one-hot ctrl slot strobe,
// assembles complete frames, buffers them in a small frame FIFO and streams
// each frame out as a header word followed by NSLOT data words (valid/ready).
module ro_frame_packer #(
  parameter int              DW       = 8,
  parameter int              NSLOT    = 8,
  parameter int              FDEPTH   = 4,
  parameter logic [DW-1:0]   HDR_WORD = 8'hA5
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic [DW-1:0]    ro_bus,
  input  logic [NSLOT-1:0] ctrl,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      frame_cnt,
  output logic [7:0]       ovf_cnt,
  output logic             err_multi,
  output logic             err_inc
);

  localparam int IW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int AW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NSLOT - 1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FDEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [NSLOT-1:0] seen;
  logic [DW-1:0]    slot [NSLOT];
  logic             push_p1;

  logic [DW-1:0]    mem [FDEPTH][NSLOT];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      cnt, cnt_nxt;
  logic             full, push_ok, pop;

  logic [1:0]       state;
  logic [IW-1:0]    idx;

  logic             hit, onehot, prior_all;

  // Decode the slot strobe: any strobe, exactly one strobe, earlier slots all seen
  always_comb begin
    hit       = en && (ctrl != '0);
    onehot    = (ctrl & (ctrl - NSLOT'(1))) == '0;
    prior_all = &seen[NSLOT-2:0];
  end

  // Stage p0 -> p1: slot capture, frame completion and error flags
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      seen      <= '0;
      push_p1   <= 1'b0;
      err_multi <= 1'b0;
      err_inc   <= 1'b0;
      for (int i = 0; i < NSLOT; i++) slot[i] <= '0;
    end else begin
      push_p1 <= 1'b0;
      if (hit) begin
        if (!onehot) begin
          err_multi <= 1'b1;
        end else begin
          for (int i = 0; i < NSLOT; i++)
            if (ctrl[i]) slot[i] <= ro_bus;
          if (ctrl[NSLOT-1]) begin
            // Last slot closes the frame; incomplete frames are thrown away
            seen <= '0;
            if (prior_all) push_p1 <= 1'b1;
            else           err_inc <= 1'b1;
          end else begin
            seen <= seen | ctrl;
          end
        end
      end
    end
  end

  // FIFO push/pop decisions and next occupancy; a pop frees room for a same-cycle push
  always_comb begin
    full    = (cnt == CNT_FULL);
    pop     = (state == S_DATA) && out_ready && (idx == LAST_IDX);
    push_ok = push_p1 && (!full || pop);
    cnt_nxt = cnt;
    if (push_ok && !pop)      cnt_nxt = cnt + CNT_ONE;
    else if (!push_ok && pop) cnt_nxt = cnt - CNT_ONE;
  end

  // Stage p1 -> FIFO: snapshot the completed frame into the frame storage
  always_ff @(posedge clk) begin
    if (push_ok)
      for (int i = 0; i < NSLOT; i++) mem[wptr][i] <= slot[i];
  end

  // FIFO pointers, occupancy and saturating drop counter
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
      ovf_cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop)     rptr <= rptr + AW'(1);
      if (push_p1 && !push_ok && (ovf_cnt != 8'hFF)) ovf_cnt <= ovf_cnt + 8'd1;
    end
  end

  // FIFO -> output: header + data streaming FSM, holds word while stalled
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= S_IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      frame_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cnt != '0) begin
            state     <= S_HDR;
            out_valid <= 1'b1;
            out_data  <= HDR_WORD;
          end
        end
        S_HDR: begin
          if (out_ready) begin
            state    <= S_DATA;
            idx      <= '0;
            out_data <= mem[rptr][0];
          end
        end
        S_DATA: begin
          if (out_ready) begin
            if (idx != LAST_IDX) begin
              idx      <= idx + IW'(1);
              out_data <= mem[rptr][idx + IW'(1)];
            end else begin
              frame_cnt <= frame_cnt + 16'd1;
              // Go straight to the next header when another frame is waiting
              if (cnt_nxt != '0) begin
                state    <= S_HDR;
                out_data <= HDR_WORD;
              end else begin
                state     <= S_IDLE;
                out_valid <= 1'b0;
                out_data  <= '0;
              end
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_frame_packer.sv
// Directed self-checking bench for ro_frame_packer.
module tb_ro_frame_packer;
  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  ro_bus = '0;
  logic [7:0]  ctrl = '0;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [15:0] frame_cnt;
  logic [7:0]  ovf_cnt;
  logic        err_multi;
  logic        err_inc;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q[$];
  int         cq[$];
  bit         mon_en = 1'b0;
  bit         rnd_mode = 1'b0;
  int         cyc = 0;
  logic       pv, pr;
  logic [7:0] pd;

  ro_frame_packer #(.DW(8), .NSLOT(8), .FDEPTH(4), .HDR_WORD(8'hA5)) dut (
    .clk(clk), .rstb(rstb), .en(en), .ro_bus(ro_bus), .ctrl(ctrl),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .frame_cnt(frame_cnt), .ovf_cnt(ovf_cnt), .err_multi(err_multi), .err_inc(err_inc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Words seen valid&&ready at the negedge are accepted at the following posedge
  always @(negedge clk)
    if (mon_en && out_valid && out_ready) begin
      q.push_back(out_data);
      cq.push_back(cyc);
    end

  // One clock of stimulus; in random mode also toggles out_ready and checks stall hold
  task automatic drive(input logic e, input logic [7:0] c, input logic [7:0] b);
    en = e; ctrl = c; ro_bus = b;
    if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
    pv = out_valid; pr = out_ready; pd = out_data;
    @(posedge clk); #1;
    if (rnd_mode && pv && !pr) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== pd) begin
        n_err++;
        $display("FAIL stall_hold: got valid=%b data=%h, want valid=1 data=%h", out_valid, out_data, pd);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 8'h00);
  endtask

  task automatic send_frame(input logic [7:0] base);
    logic [7:0] oh;
    for (int k = 0; k < 8; k++) begin
      oh = 8'd1 << k;
      drive(1'b1, oh, 8'(base + k));
    end
  endtask

  task automatic do_reset();
    rstb = 1'b0; en = 1'b0; ctrl = '0; ro_bus = '0; out_ready = 1'b0;
    rnd_mode = 1'b0; mon_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;
    q.delete(); cq.delete();
  endtask

  task automatic test_reset();
    bit anyv;
    do_reset();
    n_cmp++;
    if ({out_data, out_valid, frame_cnt, ovf_cnt, err_multi, err_inc} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got data=%h v=%b fc=%0d ovf=%0d em=%b ei=%b, want all 0",
               out_data, out_valid, frame_cnt, ovf_cnt, err_multi, err_inc);
    end
    anyv = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (out_valid !== 1'b0) anyv = 1'b1;
    end
    n_cmp++;
    if (anyv !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: got out_valid seen=%b, want 0", anyv);
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    out_ready = 1'b1;
    send_frame(8'h10);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL lat_edge_n: got valid=%b, want 0", out_valid);
    end
    idle(1);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL lat_edge_n1: got valid=%b, want 0", out_valid);
    end
    idle(1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      n_err++; $display("FAIL lat_hdr: got valid=%b data=%h, want 1 a5", out_valid, out_data);
    end
    for (int k = 0; k < 8; k++) begin
      idle(1);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 8'(8'h10 + k)) begin
        n_err++;
        $display("FAIL single_word%0d: got valid=%b data=%h, want 1 %h", k, out_valid, out_data, 8'(8'h10 + k));
      end
    end
    idle(1);
    n_cmp++;
    if (out_valid !== 1'b0 || frame_cnt !== 16'd1) begin
      n_err++; $display("FAIL single_end: got valid=%b fc=%0d, want 0 1", out_valid, frame_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp;
    do_reset();
    out_ready = 1'b0;
    for (int f = 0; f < 5; f++) send_frame(8'(8'h20 + 16 * f));
    idle(5);
    n_cmp++;
    if (ovf_cnt !== 8'd1 || out_valid !== 1'b1 || out_data !== 8'hA5 || frame_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL bp_stalled: got ovf=%0d v=%b data=%h fc=%0d, want 1 1 a5 0", ovf_cnt, out_valid, out_data, frame_cnt);
    end
    mon_en = 1'b1;
    out_ready = 1'b1;
    idle(45);
    mon_en = 1'b0;
    n_cmp++;
    if (q.size() !== 36) begin
      n_err++; $display("FAIL bp_count: got %0d words, want 36", q.size());
    end else begin
      for (int i = 0; i < 36; i++) begin
        exp = (i % 9 == 0) ? 8'hA5 : 8'(8'h20 + 16 * (i / 9) + (i % 9) - 1);
        n_cmp++;
        if (q[i] !== exp) begin
          n_err++; $display("FAIL bp_word%0d: got %h, want %h", i, q[i], exp);
        end
      end
      n_cmp++;
      if (cq[35] - cq[0] !== 35) begin
        n_err++; $display("FAIL bp_no_bubble: got span %0d cycles, want 35", cq[35] - cq[0]);
      end
    end
    n_cmp++;
    if (frame_cnt !== 16'd4 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_end: got fc=%0d v=%b, want 4 0", frame_cnt, out_valid);
    end
  endtask

  task automatic test_errors();
    logic [7:0] oh;
    logic [7:0] exp;
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 8'h03, 8'hEE);
    n_cmp++;
    if (err_multi !== 1'b1 || err_inc !== 1'b0) begin
      n_err++; $display("FAIL err_multi_set: got em=%b ei=%b, want 1 0", err_multi, err_inc);
    end
    mon_en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      oh = 8'd1 << k;
      drive(1'b1, oh, 8'(8'h30 + k));
    end
    drive(1'b1, 8'hC0, 8'hEE);
    drive(1'b1, 8'h80, 8'h37);
    idle(14);
    n_cmp++;
    if (q.size() !== 9) begin
      n_err++; $display("FAIL err_frame1_count: got %0d words, want 9", q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        exp = (i == 0) ? 8'hA5 : 8'(8'h30 + i - 1);
        n_cmp++;
        if (q[i] !== exp) begin
          n_err++; $display("FAIL err_frame1_word%0d: got %h, want %h", i, q[i], exp);
        end
      end
    end
    n_cmp++;
    if (err_inc !== 1'b0 || frame_cnt !== 16'd1) begin
      n_err++; $display("FAIL err_frame1_end: got ei=%b fc=%0d, want 0 1", err_inc, frame_cnt);
    end
    q.delete();
    for (int k = 0; k < 6; k++) begin
      oh = 8'd1 << k;
      drive(1'b1, oh, 8'(8'h60 + k));
    end
    drive(1'b1, 8'h80, 8'h99);
    n_cmp++;
    if (err_inc !== 1'b1) begin
      n_err++; $display("FAIL err_inc_set: got %b, want 1", err_inc);
    end
    idle(12);
    n_cmp++;
    if (q.size() !== 0 || frame_cnt !== 16'd1) begin
      n_err++; $display("FAIL err_inc_drop: got %0d words fc=%0d, want 0 1", q.size(), frame_cnt);
    end
    send_frame(8'h70);
    idle(14);
    mon_en = 1'b0;
    n_cmp++;
    if (q.size() !== 9) begin
      n_err++; $display("FAIL err_frame2_count: got %0d words, want 9", q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        exp = (i == 0) ? 8'hA5 : 8'(8'h70 + i - 1);
        n_cmp++;
        if (q[i] !== exp) begin
          n_err++; $display("FAIL err_frame2_word%0d: got %h, want %h", i, q[i], exp);
        end
      end
    end
    n_cmp++;
    if (frame_cnt !== 16'd2 || err_multi !== 1'b1 || err_inc !== 1'b1) begin
      n_err++; $display("FAIL err_sticky: got fc=%0d em=%b ei=%b, want 2 1 1", frame_cnt, err_multi, err_inc);
    end
  endtask

  task automatic test_random_ready();
    logic [7:0] exp;
    do_reset();
    mon_en = 1'b1;
    rnd_mode = 1'b1;
    for (int f = 0; f < 50; f++) begin
      send_frame(8'(5 * f));
      idle(24);
    end
    rnd_mode = 1'b0;
    out_ready = 1'b1;
    idle(60);
    mon_en = 1'b0;
    n_cmp++;
    if (q.size() !== 450) begin
      n_err++; $display("FAIL rnd_count: got %0d words, want 450", q.size());
    end else begin
      for (int i = 0; i < 450; i++) begin
        exp = (i % 9 == 0) ? 8'hA5 : 8'(5 * (i / 9) + (i % 9) - 1);
        n_cmp++;
        if (q[i] !== exp) begin
          n_err++; $display("FAIL rnd_word%0d: got %h, want %h", i, q[i], exp);
        end
      end
    end
    n_cmp++;
    if (frame_cnt !== 16'd50 || ovf_cnt !== 8'd0) begin
      n_err++; $display("FAIL rnd_end: got fc=%0d ovf=%0d, want 50 0", frame_cnt, ovf_cnt);
    end
  endtask

  task automatic test_reset_mid_data();
    bit anyv;
    logic [7:0] exp;
    do_reset();
    out_ready = 1'b1;
    send_frame(8'h80);
    idle(4);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'h81) begin
      n_err++; $display("FAIL mid_pre: got v=%b data=%h, want 1 81", out_valid, out_data);
    end
    #2 rstb = 1'b0;
    #1;
    n_cmp++;
    if ({out_data, out_valid, frame_cnt, ovf_cnt, err_multi, err_inc} !== '0) begin
      n_err++;
      $display("FAIL mid_async_reset: got data=%h v=%b fc=%0d ovf=%0d em=%b ei=%b, want all 0",
               out_data, out_valid, frame_cnt, ovf_cnt, err_multi, err_inc);
    end
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;
    anyv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      if (out_valid !== 1'b0) anyv = 1'b1;
    end
    n_cmp++;
    if (anyv !== 1'b0 || frame_cnt !== 16'd0) begin
      n_err++; $display("FAIL mid_discard: got valid seen=%b fc=%0d, want 0 0", anyv, frame_cnt);
    end
    q.delete(); cq.delete();
    mon_en = 1'b1;
    send_frame(8'h90);
    idle(14);
    mon_en = 1'b0;
    n_cmp++;
    if (q.size() !== 9) begin
      n_err++; $display("FAIL mid_after_count: got %0d words, want 9", q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        exp = (i == 0) ? 8'hA5 : 8'(8'h90 + i - 1);
        n_cmp++;
        if (q[i] !== exp) begin
          n_err++; $display("FAIL mid_after_word%0d: got %h, want %h", i, q[i], exp);
        end
      end
    end
    n_cmp++;
    if (frame_cnt !== 16'd1) begin
      n_err++; $display("FAIL mid_after_fc: got %0d, want 1", frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_errors();
    test_random_ready();
    test_reset_mid_data();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
